ps2_keyb_fifo: RTL and testbench
================================

# ps2_keyb_fifo

Parametrised PS/2 keyboard receive front end that replaces the single-register scan-code path. It synchronises and glitch-filters the PS/2 clock and data lines, decodes 11-bit frames with parity and timeout checking, and folds the E0/F0 prefixes into flags. Complete key events are buffered in a show-ahead FIFO so a slow consumer does not lose codes: either the CPU-side register interface or the scancode-to-matrix translator. It sits between the PS/2 pins and the keyboard consumers in the keyboard subsystem.

## Interface
Parameters:
- FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW events (8)
- FILTER_LEN, 8, consecutive identical samples needed to change the filtered ps2 clock level
- TIMEOUT_CYCLES, 28000, clk cycles without a filtered falling edge before an in-progress frame is abandoned

Ports:
- clk  in  1  system clock; all logic in this domain
- rst  in  1  asynchronous, active-high reset
- ps2clk_ext  in  1  raw PS/2 clock pin
- ps2data_ext  in  1  raw PS/2 data pin
- enable_rcv  in  1  1 = receive; 0 = frame FSM held in IDLE and edges ignored
- rd  in  1  pop head event; ignored when empty
- event_valid  out  1  FIFO not empty
- scancode  out  8  head event code
- extended  out  1  head event was E0-prefixed
- released  out  1  head event was F0-prefixed
- level  out  FIFO_AW+1  number of stored events
- overflow  out  1  sticky: an event was dropped because the FIFO was full
- rx_error  out  1  sticky: parity, stop-bit or timeout error
- clr_err  in  1  clears overflow and rx_error

## Operation
- Both pins pass through 2-FF synchronisers. A saturating counter filters the clock: the filtered level flips only after FILTER_LEN consecutive samples at the opposite value. The data pin is only synchronised.
- A filtered falling edge is a 1-cycle strobe. Data is sampled on that strobe.
- Frame FSM: IDLE -> (edge, data=0) DATA -> 8 edges, LSB first -> PARITY -> STOP -> IDLE.
  - An edge in IDLE with data=1 is a false start: stay in IDLE, no error.
  - Parity is odd over 8 data bits plus the parity bit. Stop must be 1.
- Byte completes at STOP with parity and stop both good:
  - 0xE0: set ext flag. 0xF0: set rel flag. Neither is pushed.
  - Any other byte, including 0xE1: push {ext, rel, byte}, then clear both flags.
- Parity or stop failure: discard the byte, set rx_error, clear both flags.
- Timeout: in any state other than IDLE, if TIMEOUT_CYCLES pass with no edge, go to IDLE, set rx_error and clear both flags. The counter restarts on every edge.
- FIFO is show-ahead: scancode, extended and released always show the head entry. They are 0 when empty.
  - Push when full is dropped and sets overflow.
  - Push and rd in the same cycle when full: both happen and level is unchanged.
  - Push and rd in the same cycle when empty: the push is stored and the rd is ignored.
  - Pointers wrap modulo 2**FIFO_AW. level is stored separately, not derived from the pointers.
- clr_err has priority over a same-cycle error set.
- enable_rcv falling mid-frame forces IDLE and clears the flags; no error is flagged. FIFO contents are kept.
- rst mid-frame or with FIFO data: everything clears immediately and asynchronously.

## Timing
- Reset values:
  - event_valid, scancode, extended, released, level, overflow, rx_error = 0.
  - FSM = IDLE, prefix flags = 0, filtered clock = 1, filter counter = 0.
- Raw ps2clk falling edge to strobe: 2 sync cycles + FILTER_LEN cycles.
- Stop-bit strobe in cycle N: FIFO write at the edge ending cycle N. event_valid, head data and level update in cycle N+1.
- rd sampled at cycle M: head advances and level decrements in cycle M+1.
- rx_error and overflow assert the cycle after the causing event.
- Minimum PS/2 clock half-period handled: FILTER_LEN+3 clk cycles.

## Test plan
- Frame 0x1C (parity 0, stop 1), rd held 0 -> event_valid=1, scancode=0x1C, extended=0, released=0, level=1, one cycle after the stop strobe.
- Sequence E0 F0 75 -> exactly one event: scancode=0x75, extended=1, released=1. A following 0x75 frame gives extended=0, released=0.
- Frame 0x1C with parity bit 1 -> no push, rx_error=1, level unchanged. A subsequent F0-prefixed code is unaffected by stale flags. clr_err -> rx_error=0.
- Start bit followed by 3 data bits, then silence for TIMEOUT_CYCLES+1 -> FSM IDLE, rx_error=1. A next clean frame 0x2A is received correctly.
- FIFO_AW=3: push 9 codes 0x01..0x09 with no rd -> level=8, overflow=1, head=0x01. Eight rd pops yield 0x01..0x08. Push and rd in the same cycle at full keeps level=8.
- Assert rst during the DATA state with 3 events queued -> all outputs 0 immediately. The next full frame decodes normally.

Source files
------------

// File: rtl/ps2_keyb_fifo.sv
// PS/2 keyboard receive front end: pin synchronisers, clock glitch filter,
// frame decoder with E0/F0 prefix folding, and a show-ahead event FIFO.
//
// state    | meaning
// S_IDLE   | waiting for a start bit (data low on a filtered falling edge)
// S_DATA   | shifting in 8 data bits, LSB first
// S_PARITY | capturing the odd-parity bit
// S_STOP   | checking the stop bit, then push / prefix / error
module ps2_keyb_fifo #(
  parameter int FIFO_AW        = 3,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 28000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ps2clk_ext,
  input  logic               ps2data_ext,
  input  logic               enable_rcv,
  input  logic               rd,
  output logic               event_valid,
  output logic [7:0]         scancode,
  output logic               extended,
  output logic               released,
  output logic [FIFO_AW:0]   level,
  output logic               overflow,
  output logic               rx_error,
  input  logic               clr_err
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int FW    = $clog2(FILTER_LEN + 1);
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [1:0]         clk_sync, dat_sync;
  logic               filt, filt_d;
  logic [FW-1:0]      fcnt;
  logic               edge_stb, dat_s;
  state_t             state, state_nx;
  logic [7:0]         shift;
  logic [2:0]         bit_cnt;
  logic               par_bit;
  logic               ext_flag, rel_flag;
  logic [TW-1:0]      tcnt;
  logic               push, frame_err, set_ext, set_rel, flag_clr, to_expired;
  logic [9:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic               empty, full, do_rd, do_wr, ovf_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2clk_ext};
      dat_sync <= {dat_sync[0], ps2data_ext};
    end
  end

  // The filtered level only flips after FILTER_LEN consecutive opposite samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt   <= 1'b1;
      filt_d <= 1'b1;
      fcnt   <= '0;
    end else begin
      filt_d <= filt;
      if (clk_sync[1] == filt) begin
        fcnt <= '0;
      end else if (fcnt == FW'(FILTER_LEN - 1)) begin
        filt <= ~filt;
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  assign edge_stb   = filt_d & ~filt & enable_rcv;
  assign dat_s      = dat_sync[1];
  assign to_expired = (state != S_IDLE) && !edge_stb && (tcnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    push      = 1'b0;
    frame_err = 1'b0;
    set_ext   = 1'b0;
    set_rel   = 1'b0;
    case (state)
      S_IDLE:   if (edge_stb && !dat_s) state_nx = S_DATA;
      S_DATA:   if (edge_stb && bit_cnt == 3'd7) state_nx = S_PARITY;
      S_PARITY: if (edge_stb) state_nx = S_STOP;
      S_STOP: begin
        if (edge_stb) begin
          state_nx = S_IDLE;
          if (dat_s && (^{shift, par_bit})) begin
            if (shift == 8'hE0)      set_ext = 1'b1;
            else if (shift == 8'hF0) set_rel = 1'b1;
            else                     push    = 1'b1;
          end else begin
            frame_err = 1'b1;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
    if (to_expired) begin
      state_nx  = S_IDLE;
      frame_err = 1'b1;
    end
    if (!enable_rcv) begin
      state_nx  = S_IDLE;
      push      = 1'b0;
      frame_err = 1'b0;
      set_ext   = 1'b0;
      set_rel   = 1'b0;
    end
  end

  assign flag_clr = push | frame_err | ~enable_rcv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift    <= '0;
      bit_cnt  <= '0;
      par_bit  <= 1'b0;
      ext_flag <= 1'b0;
      rel_flag <= 1'b0;
      tcnt     <= TW'(TIMEOUT_CYCLES - 1);
    end else begin
      if (edge_stb) begin
        case (state)
          S_IDLE:   bit_cnt <= '0;
          S_DATA: begin
            shift   <= {dat_s, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
          S_PARITY: par_bit <= dat_s;
          default:  ;
        endcase
      end
      if (flag_clr) begin
        ext_flag <= 1'b0;
        rel_flag <= 1'b0;
      end else begin
        if (set_ext) ext_flag <= 1'b1;
        if (set_rel) rel_flag <= 1'b1;
      end
      // Down-counter restarts on every edge and is parked while idle.
      if (state == S_IDLE || edge_stb) tcnt <= TW'(TIMEOUT_CYCLES - 1);
      else if (tcnt != '0)             tcnt <= tcnt - 1'b1;
    end
  end

  assign empty   = (level == '0);
  assign full    = (level == (FIFO_AW + 1)'(DEPTH));
  assign do_rd   = rd & ~empty;
  assign do_wr   = push & (~full | do_rd);
  assign ovf_set = push & full & ~do_rd;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= {ext_flag, rel_flag, shift};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      rx_error <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
      if (clr_err) begin
        overflow <= 1'b0;
        rx_error <= 1'b0;
      end else begin
        if (ovf_set)   overflow <= 1'b1;
        if (frame_err) rx_error <= 1'b1;
      end
    end
  end

  assign event_valid = ~empty;
  assign {extended, released, scancode} = empty ? 10'd0 : mem[rd_ptr];

endmodule

// File: tb/tb_ps2_keyb_fifo.sv
// Self-checking bench for ps2_keyb_fifo: queue-based event model compared
// every cycle, plus literal expectations at key points.
module tb_ps2_keyb_fifo;
  localparam int AW = 3, FL = 4, TO = 400, H = 20, DEPTH = 8;

  logic clk = 0, rst = 1, ps2clk_ext = 1, ps2data_ext = 1;
  logic enable_rcv = 1, rd = 0, clr_err = 0;
  logic event_valid, extended, released, overflow, rx_error;
  logic [7:0] scancode;
  logic [AW:0] level;

  ps2_keyb_fifo #(.FIFO_AW(AW), .FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ps2clk_ext(ps2clk_ext), .ps2data_ext(ps2data_ext),
    .enable_rcv(enable_rcv), .rd(rd), .event_valid(event_valid),
    .scancode(scancode), .extended(extended), .released(released),
    .level(level), .overflow(overflow), .rx_error(rx_error), .clr_err(clr_err));

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  bit chk_en = 0;
  logic [9:0] mq[$];
  bit m_ext = 0, m_rel = 0, m_ovf = 0, m_err = 0;

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [9:0] h;
      h = (mq.size() != 0) ? mq[0] : 10'd0;
      chk("event_valid", 16'(event_valid), 16'(mq.size() != 0));
      chk("scancode", 16'(scancode), 16'(h[7:0]));
      chk("extended", 16'(extended), 16'(h[9]));
      chk("released", 16'(released), 16'(h[8]));
      chk("level", 16'(level), 16'(mq.size()));
      chk("overflow", 16'(overflow), 16'(m_ovf));
      chk("rx_error", 16'(rx_error), 16'(m_err));
    end
  end

  task automatic ticks(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(logic b);
    ps2data_ext = b;
    ticks(H / 2);
    ps2clk_ext = 0;
    ticks(H);
    ps2clk_ext = 1;
    ticks(H / 2);
  endtask

  task automatic model_stop(logic [7:0] b, bit good, bit rd_at);
    if (rd_at && mq.size() > 0) void'(mq.pop_front());
    if (!good) begin
      m_err = 1; m_ext = 0; m_rel = 0;
    end else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_rel = 1;
    else begin
      if (mq.size() < DEPTH) mq.push_back({m_ext, m_rel, b});
      else m_ovf = 1;
      m_ext = 0; m_rel = 0;
    end
  endtask

  // The stop-bit strobe lands 2+FL cycles after the raw fall; the model
  // updates right after the clock edge that ends the strobe cycle.
  task automatic send_frame(logic [7:0] b, bit bad_par = 0, bit bad_stop = 0, bit rd_at = 0);
    logic [10:0] bits;
    logic p;
    p = (~^b) ^ bad_par;
    bits = {~bad_stop, p, b, 1'b0};
    for (int i = 0; i < 10; i++) ps2_bit(bits[i]);
    ps2data_ext = bits[10];
    ticks(H / 2);
    ps2clk_ext = 0;
    ticks(2 + FL);
    if (rd_at) rd = 1;
    ticks(1);
    rd = 0;
    model_stop(b, !bad_par && !bad_stop, rd_at);
    ticks(H - 3 - FL);
    ps2clk_ext = 1;
    ps2data_ext = 1;
    ticks(H / 2);
  endtask

  task automatic pop();
    rd = 1;
    ticks(1);
    rd = 0;
    if (mq.size() > 0) void'(mq.pop_front());
    ticks(2);
  endtask

  task automatic do_clr();
    clr_err = 1;
    ticks(1);
    clr_err = 0;
    m_err = 0; m_ovf = 0;
    ticks(2);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_valid"}, 16'(event_valid), 16'd0);
    chk({tag, "_code"}, 16'(scancode), 16'd0);
    chk({tag, "_ext"}, 16'(extended), 16'd0);
    chk({tag, "_rel"}, 16'(released), 16'd0);
    chk({tag, "_level"}, 16'(level), 16'd0);
    chk({tag, "_ovf"}, 16'(overflow), 16'd0);
    chk({tag, "_err"}, 16'(rx_error), 16'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 chk_zero("reset");
    #20 rst = 0;
    ticks(3);
    chk_en = 1;

    // sub-filter-length glitch with data low must not start a frame
    ps2data_ext = 0; ps2clk_ext = 0;
    ticks(FL - 1);
    ps2clk_ext = 1; ps2data_ext = 1;
    ticks(30);

    send_frame(8'h1C);
    chk("t1_code", 16'(scancode), 16'h1C);
    chk("t1_level", 16'(level), 16'd1);
    chk("t1_flags", 16'({extended, released}), 16'd0);
    pop();
    chk("t1_empty", 16'(event_valid), 16'd0);

    send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h75);
    chk("t2_code", 16'(scancode), 16'h75);
    chk("t2_flags", 16'({extended, released}), 16'b11);
    chk("t2_level", 16'(level), 16'd1);
    send_frame(8'h75);
    pop();
    chk("t2b_code", 16'(scancode), 16'h75);
    chk("t2b_flags", 16'({extended, released}), 16'b00);
    pop();

    send_frame(8'hE0); send_frame(8'h1C, 1);
    chk("t3_err", 16'(rx_error), 16'd1);
    chk("t3_level", 16'(level), 16'd0);
    send_frame(8'hF0); send_frame(8'h1C);
    chk("t3_flags", 16'({extended, released}), 16'b01);
    do_clr();
    chk("t3_clr", 16'(rx_error), 16'd0);
    pop();

    send_frame(8'h22, 0, 1);
    chk("stop_err", 16'(rx_error), 16'd1);
    do_clr();

    chk_en = 0;
    ps2_bit(0); ps2_bit(1); ps2_bit(0); ps2_bit(1);
    ticks(TO + 20);
    m_err = 1; m_ext = 0; m_rel = 0;
    chk_en = 1;
    chk("to_err", 16'(rx_error), 16'd1);
    do_clr();
    send_frame(8'h2A);
    chk("to_next", 16'(scancode), 16'h2A);
    pop();

    send_frame(8'hE0);
    ps2_bit(0); ps2_bit(1); ps2_bit(1);
    enable_rcv = 0;
    ticks(5);
    enable_rcv = 1;
    m_ext = 0; m_rel = 0;
    ticks(5);
    send_frame(8'h44);
    chk("en_flags", 16'({extended, released}), 16'b00);
    chk("en_err", 16'(rx_error), 16'd0);
    pop();

    for (int i = 1; i <= 9; i++) send_frame(8'(i));
    chk("ovf_level", 16'(level), 16'd8);
    chk("ovf_flag", 16'(overflow), 16'd1);
    chk("ovf_head", 16'(scancode), 16'h01);
    for (int i = 1; i <= 8; i++) begin
      chk("ovf_pop", 16'(scancode), 16'(i));
      pop();
    end
    do_clr();
    for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i));
    send_frame(8'h18, 0, 0, 1);
    chk("full_rw_level", 16'(level), 16'd8);
    chk("full_rw_ovf", 16'(overflow), 16'd0);
    chk("full_rw_head", 16'(scancode), 16'h11);
    for (int i = 0; i < 8; i++) pop();
    send_frame(8'h5A, 0, 0, 1);
    chk("empty_rw_level", 16'(level), 16'd1);
    chk("empty_rw_code", 16'(scancode), 16'h5A);
    pop();

    send_frame(8'h61); send_frame(8'h62); send_frame(8'h63);
    ps2_bit(0); ps2_bit(1); ps2_bit(1); ps2_bit(0);
    chk_en = 0;
    #3 rst = 1;
    #1 chk_zero("rst_mid");
    mq.delete();
    m_ext = 0; m_rel = 0; m_ovf = 0; m_err = 0;
    ticks(3);
    #2 rst = 0;
    ticks(3);
    chk_en = 1;
    send_frame(8'h29);
    chk("post_rst_code", 16'(scancode), 16'h29);
    chk("post_rst_level", 16'(level), 16'd1);
    ticks(5);

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
